fc_logits_10: RTL and testbench

//   Final fully-connected (dense) layer of the MNIST CNN classifier; produces ten signed 64-bit class logits.

---
 rtl/fc_logits_10.sv | 77 +++++++
 tb/tb_fc_logits_10.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fc_logits_10.sv
// fc_logits_10: ten-class dense output layer; streams N_IN activations and accumulates biased signed logits.
module fc_logits_10 #(
    parameter int N_IN   = 128,
    parameter int IN_W   = 16,
    parameter int W_W    = 16,
    parameter int BIAS_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [10*BIAS_W-1:0] bias_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic [10*W_W-1:0]    wgt_in,
    output logic [ACC_W-1:0]     logit0,
    output logic [ACC_W-1:0]     logit1,
    output logic [ACC_W-1:0]     logit2,
    output logic [ACC_W-1:0]     logit3,
    output logic [ACC_W-1:0]     logit4,
    output logic [ACC_W-1:0]     logit5,
    output logic [ACC_W-1:0]     logit6,
    output logic [ACC_W-1:0]     logit7,
    output logic [ACC_W-1:0]     logit8,
    output logic [ACC_W-1:0]     logit9,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(N_IN + 1);
    localparam int PW = IN_W + W_W;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [ACC_W-1:0] r_acc [10];
    logic [ACC_W-1:0] w_bias [10];
    logic [ACC_W-1:0] w_prod [10];
    logic             w_load, w_beat, w_last;
    for (genvar k = 0; k < 10; k++) begin : g_lane
        logic signed [PW-1:0] w_mul;
        assign w_mul     = $signed(in_data) * $signed(wgt_in[k*W_W +: W_W]);
        assign w_prod[k] = {{(ACC_W-PW){w_mul[PW-1]}}, w_mul};
        assign w_bias[k] = {{(ACC_W-BIAS_W){bias_in[k*BIAS_W+BIAS_W-1]}}, bias_in[k*BIAS_W +: BIAS_W]};
    end
    assign w_load   = start && r_state != ACC;
    assign w_beat   = in_valid && r_state == ACC;
    assign w_last   = r_cnt == CW'(N_IN - 1);
    assign in_ready = r_state == ACC;
    assign busy     = r_state == ACC;
    assign done     = r_state == DONE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            for (int k = 0; k < 10; k++) r_acc[k] <= '0;
        end else if (w_load) begin
            r_state <= ACC;
            r_cnt   <= '0;
            for (int k = 0; k < 10; k++) r_acc[k] <= w_bias[k];
        end else if (w_beat) begin
            // counter parks at 0 after the last beat so it never exceeds N_IN-1
            r_state <= w_last ? DONE : ACC;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            for (int k = 0; k < 10; k++) r_acc[k] <= r_acc[k] + w_prod[k];
        end
    end
    assign logit0 = r_acc[0];
    assign logit1 = r_acc[1];
    assign logit2 = r_acc[2];
    assign logit3 = r_acc[3];
    assign logit4 = r_acc[4];
    assign logit5 = r_acc[5];
    assign logit6 = r_acc[6];
    assign logit7 = r_acc[7];
    assign logit8 = r_acc[8];
    assign logit9 = r_acc[9];
endmodule

// File: tb/tb_fc_logits_10.sv
// tb_fc_logits_10: directed and randomized checks of fc_logits_10 (N_IN=4) against an arithmetic reference.
module tb_fc_logits_10;
    localparam int N = 4;
    logic          clk = 0, resetn = 0, start = 0, in_valid = 0;
    logic [319:0]  bias_in = '0;
    logic [159:0]  wgt_in = '0;
    logic [15:0]   in_data = '0;
    logic          in_ready, busy, done;
    logic [63:0]   lg [10];
    int checks = 0, failures = 0;
    int bias_m [10];
    int data_m [N];
    int w_m [N][10];
    logic [63:0] basic [10];

    fc_logits_10 #(.N_IN(N)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .wgt_in(wgt_in),
        .logit0(lg[0]), .logit1(lg[1]), .logit2(lg[2]), .logit3(lg[3]), .logit4(lg[4]),
        .logit5(lg[5]), .logit6(lg[6]), .logit7(lg[7]), .logit8(lg[8]), .logit9(lg[9]),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic longint model(int k);
        longint s = longint'(bias_m[k]);
        for (int b = 0; b < N; b++) s += longint'(data_m[b]) * longint'(w_m[b][k]);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_logits(input string tag);
        for (int k = 0; k < 10; k++) chk($sformatf("%s_logit%0d", tag, k), lg[k], 64'(model(k)));
    endtask

    task automatic do_start();
        for (int k = 0; k < 10; k++) bias_in[k*32 +: 32] = 32'(bias_m[k]);
        start = 1;
        @(negedge clk);
        start = 0;
        bias_in = {10{32'($urandom)}};
    endtask

    task automatic beat(input int b);
        in_valid = 1;
        in_data  = 16'(data_m[b]);
        for (int k = 0; k < 10; k++) wgt_in[k*16 +: 16] = 16'(w_m[b][k]);
        @(negedge clk);
        in_valid = 0;
        in_data  = 16'($urandom);
        wgt_in   = {5{32'($urandom)}};
    endtask

    task automatic idle_cycle(input bit pulse);
        start = pulse;
        bias_in = {10{32'($urandom)}};
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(input string tag, input int gap_max, input bit pulse);
        do_start();
        chk({tag, "_done_fell"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        for (int b = 0; b < N; b++) begin
            int g = $urandom_range(0, gap_max);
            repeat (g) idle_cycle(1'b0);
            if (pulse && b == 2) idle_cycle(1'b1);
            beat(b);
            chk($sformatf("%s_done_after_beat%0d", tag, b), 64'(done), 64'(b == N - 1));
        end
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready_end"}, 64'(in_ready), 64'd0);
        chk_logits(tag);
    endtask

    task automatic set_basic();
        for (int k = 0; k < 10; k++) bias_m[k] = 0;
        for (int b = 0; b < N; b++) begin
            data_m[b] = b + 1;
            for (int k = 0; k < 10; k++) w_m[b][k] = k + 1;
        end
    endtask

    initial begin
        for (int k = 0; k < 10; k++) basic[k] = 64'(10 * (k + 1));
        // reset
        #3;
        for (int k = 0; k < 10; k++) chk($sformatf("rst_logit%0d", k), lg[k], 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        resetn = 1;
        in_valid = 1;
        in_data = 16'd7;
        wgt_in = {10{16'd3}};
        repeat (3) @(negedge clk);
        in_valid = 0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_logit0", lg[0], 64'd0);
        // basic
        set_basic();
        run("basic", 0, 1'b0);
        for (int k = 0; k < 10; k++) chk($sformatf("basic_const%0d", k), lg[k], basic[k]);
        // in_valid while DONE is not accepted
        in_valid = 1;
        in_data = 16'd9;
        @(negedge clk);
        in_valid = 0;
        chk("done_hold_logit9", lg[9], 64'd100);
        chk("done_hold_done", 64'(done), 64'd1);
        // signed
        for (int k = 0; k < 10; k++) bias_m[k] = -7;
        for (int b = 0; b < N; b++) begin
            data_m[b] = -3;
            for (int k = 0; k < 10; k++) w_m[b][k] = 5;
        end
        run("signed", 0, 1'b0);
        for (int k = 0; k < 10; k++) chk($sformatf("signed_const%0d", k), lg[k], 64'hFFFF_FFFF_FFFF_FFBD);
        // backpressure with a start pulse in ACC
        set_basic();
        run("bp", 3, 1'b1);
        for (int k = 0; k < 10; k++) chk($sformatf("bp_const%0d", k), lg[k], basic[k]);
        // restart
        for (int k = 0; k < 10; k++) bias_m[k] = 100;
        for (int b = 0; b < N; b++) data_m[b] = 0;
        run("restart", 1, 1'b0);
        for (int k = 0; k < 10; k++) chk($sformatf("restart_const%0d", k), lg[k], 64'd100);
        // async reset mid-ACC
        set_basic();
        do_start();
        beat(0);
        beat(1);
        #2 resetn = 0;
        #1;
        for (int k = 0; k < 10; k++) chk($sformatf("arst_logit%0d", k), lg[k], 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("arst_idle_busy", 64'(busy), 64'd0);
        run("after_rst", 0, 1'b0);
        for (int k = 0; k < 10; k++) chk($sformatf("after_rst_const%0d", k), lg[k], basic[k]);
        // extreme operands: full-width signed product
        for (int k = 0; k < 10; k++) bias_m[k] = (k % 2 == 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
        for (int b = 0; b < N; b++) begin
            data_m[b] = -32768;
            for (int k = 0; k < 10; k++) w_m[b][k] = (k < 5) ? -32768 : 32767;
        end
        run("extreme", 0, 1'b0);
        // randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 10; k++) bias_m[k] = int'($urandom);
            for (int b = 0; b < N; b++) begin
                data_m[b] = int'($urandom_range(0, 65535)) - 32768;
                for (int k = 0; k < 10; k++) w_m[b][k] = int'($urandom_range(0, 65535)) - 32768;
            end
            run($sformatf("rand%0d", r), 3, r[0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
